// File: rtl/regmap_pckg.sv
// regmap_pckg: shared widths, read latency and read-tag type for the regmap arbiter
package regmap_pckg;
  localparam int C_S_AXI_ADDR_WDT    = 16;
  localparam int C_REGMAP_DATA_WDT   = 32;
  localparam int C_S_AXI_STRB_WDT    = C_REGMAP_DATA_WDT / 8;
  localparam int C_REGMAP_ARB_RD_LAT = 2;
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;
  localparam int RD_TAG_WDT = $bits(rd_tag_t);
endpackage

// File: rtl/del_chain.sv
// del_chain: fixed-length shift register delaying a word by DEL_CYC_LEN cycles
module del_chain #(
  parameter int IN_WORD_WDT = 1,
  parameter int DEL_CYC_LEN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IN_WORD_WDT-1:0] in_word,
  output logic [IN_WORD_WDT-1:0] out_word
);
  logic [IN_WORD_WDT-1:0] sr [DEL_CYC_LEN];
  // shift one stage per cycle; reset flushes every stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEL_CYC_LEN; i++) sr[i] <= '0;
    else begin
      sr[0] <= in_word;
      for (int i = 1; i < DEL_CYC_LEN; i++) sr[i] <= sr[i-1];
    end
  assign out_word = sr[DEL_CYC_LEN-1];
endmodule

// File: rtl/regmap_arb.sv
// regmap_arb: two-requester round-robin arbiter for regmap read and write channels
module regmap_arb
  import regmap_pckg::*;
#(
  parameter int ADDR_WDT = C_S_AXI_ADDR_WDT,
  parameter int DATA_WDT = C_REGMAP_DATA_WDT,
  parameter int STRB_WDT = C_S_AXI_STRB_WDT,
  parameter int RD_LAT   = C_REGMAP_ARB_RD_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_rd_en,
  input  logic [ADDR_WDT-1:0] req0_rd_addr,
  output logic                req0_rd_gnt,
  output logic [DATA_WDT-1:0] req0_rd_data,
  output logic                req0_rd_val,
  input  logic                req0_wr_en,
  input  logic [ADDR_WDT-1:0] req0_wr_addr,
  input  logic [DATA_WDT-1:0] req0_wr_data,
  input  logic [STRB_WDT-1:0] req0_wr_strb,
  output logic                req0_wr_gnt,
  input  logic                req1_rd_en,
  input  logic [ADDR_WDT-1:0] req1_rd_addr,
  output logic                req1_rd_gnt,
  output logic [DATA_WDT-1:0] req1_rd_data,
  output logic                req1_rd_val,
  input  logic                req1_wr_en,
  input  logic [ADDR_WDT-1:0] req1_wr_addr,
  input  logic [DATA_WDT-1:0] req1_wr_data,
  input  logic [STRB_WDT-1:0] req1_wr_strb,
  output logic                req1_wr_gnt,
  output logic                rm_rd_en,
  output logic [ADDR_WDT-1:0] rm_rd_addr,
  input  logic [DATA_WDT-1:0] rm_rd_data,
  input  logic                rm_rd_val,
  output logic                rm_wr_en,
  output logic [ADDR_WDT-1:0] rm_wr_addr,
  output logic [DATA_WDT-1:0] rm_wr_data,
  output logic [STRB_WDT-1:0] rm_wr_strb,
  output logic                err_orphan_rd
);
  logic                rd_last, wr_last, rd_id, wr_id, rd_go, wr_go, rd_id_q, hit;
  logic [ADDR_WDT-1:0] rd_addr_sel, wr_addr_sel;
  rd_tag_t             tag_in, tag_out;
  // pick the requester not granted last; a read colliding with a granted write waits a cycle
  always_comb begin
    rd_id       = req1_rd_en & (~req0_rd_en | ~rd_last);
    wr_id       = req1_wr_en & (~req0_wr_en | ~wr_last);
    rd_addr_sel = rd_id ? req1_rd_addr : req0_rd_addr;
    wr_addr_sel = wr_id ? req1_wr_addr : req0_wr_addr;
    wr_go       = rst_n & (req0_wr_en | req1_wr_en);
    rd_go       = rst_n & (req0_rd_en | req1_rd_en) & ~(wr_go & (wr_addr_sel == rd_addr_sel));
  end
  assign req0_rd_gnt = rd_go & ~rd_id;
  assign req1_rd_gnt = rd_go & rd_id;
  assign req0_wr_gnt = wr_go & ~wr_id;
  assign req1_wr_gnt = wr_go & wr_id;
  // register the granted command onto the regmap and advance the pointers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_last    <= 1'b1;
      wr_last    <= 1'b1;
      rm_rd_en   <= 1'b0;
      rm_rd_addr <= '0;
      rd_id_q    <= 1'b0;
      rm_wr_en   <= 1'b0;
      rm_wr_addr <= '0;
      rm_wr_data <= '0;
      rm_wr_strb <= '0;
    end else begin
      rm_rd_en <= rd_go;
      rm_wr_en <= wr_go;
      if (rd_go) begin
        rd_last    <= rd_id;
        rd_id_q    <= rd_id;
        rm_rd_addr <= rd_addr_sel;
      end
      if (wr_go) begin
        wr_last    <= wr_id;
        rm_wr_addr <= wr_addr_sel;
        rm_wr_data <= wr_id ? req1_wr_data : req0_wr_data;
        rm_wr_strb <= wr_id ? req1_wr_strb : req0_wr_strb;
      end
    end
  assign tag_in = '{valid: rm_rd_en, id: rd_id_q};
  del_chain #(.IN_WORD_WDT(RD_TAG_WDT), .DEL_CYC_LEN(RD_LAT)) u_tag_chain (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_word (tag_in),
    .out_word(tag_out)
  );
  assign hit = tag_out.valid & rm_rd_val;
  // route returning data to the tagged requester; flag data nobody asked for
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req0_rd_val   <= 1'b0;
      req1_rd_val   <= 1'b0;
      req0_rd_data  <= '0;
      req1_rd_data  <= '0;
      err_orphan_rd <= 1'b0;
    end else begin
      req0_rd_val   <= hit & ~tag_out.id;
      req1_rd_val   <= hit & tag_out.id;
      err_orphan_rd <= err_orphan_rd | (rm_rd_val & ~tag_out.valid);
      if (hit) begin
        req0_rd_data <= rm_rd_data;
        req1_rd_data <= rm_rd_data;
      end
    end
endmodule

// File: tb/tb_regmap_arb.sv
// tb_regmap_arb: directed stimulus with a queue-based response model checked every cycle
module tb_regmap_arb;
  localparam int RD_LAT = 2;
  logic        clk, rst_n, inj;
  logic        req0_rd_en, req1_rd_en, req0_wr_en, req1_wr_en;
  logic [15:0] req0_rd_addr, req1_rd_addr, req0_wr_addr, req1_wr_addr;
  logic [31:0] req0_wr_data, req1_wr_data;
  logic [3:0]  req0_wr_strb, req1_wr_strb;
  logic        req0_rd_gnt, req1_rd_gnt, req0_wr_gnt, req1_wr_gnt;
  logic        req0_rd_val, req1_rd_val;
  logic [31:0] req0_rd_data, req1_rd_data;
  logic        rm_rd_en, rm_rd_val, rm_wr_en, err_orphan_rd;
  logic [15:0] rm_rd_addr, rm_wr_addr;
  logic [31:0] rm_rd_data, rm_wr_data;
  logic [3:0]  rm_wr_strb;
  int total = 0, bad = 0;

  regmap_arb #(.ADDR_WDT(16), .DATA_WDT(32), .STRB_WDT(4), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_rd_en(req0_rd_en), .req0_rd_addr(req0_rd_addr), .req0_rd_gnt(req0_rd_gnt),
    .req0_rd_data(req0_rd_data), .req0_rd_val(req0_rd_val),
    .req0_wr_en(req0_wr_en), .req0_wr_addr(req0_wr_addr), .req0_wr_data(req0_wr_data),
    .req0_wr_strb(req0_wr_strb), .req0_wr_gnt(req0_wr_gnt),
    .req1_rd_en(req1_rd_en), .req1_rd_addr(req1_rd_addr), .req1_rd_gnt(req1_rd_gnt),
    .req1_rd_data(req1_rd_data), .req1_rd_val(req1_rd_val),
    .req1_wr_en(req1_wr_en), .req1_wr_addr(req1_wr_addr), .req1_wr_data(req1_wr_data),
    .req1_wr_strb(req1_wr_strb), .req1_wr_gnt(req1_wr_gnt),
    .rm_rd_en(rm_rd_en), .rm_rd_addr(rm_rd_addr), .rm_rd_data(rm_rd_data), .rm_rd_val(rm_rd_val),
    .rm_wr_en(rm_wr_en), .rm_wr_addr(rm_wr_addr), .rm_wr_data(rm_wr_data), .rm_wr_strb(rm_wr_strb),
    .err_orphan_rd(err_orphan_rd)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // regmap stand-in: memory with fixed read latency, plus an orphan-response injector
  logic [31:0] mem [256];
  logic        pv [RD_LAT];
  logic [31:0] pd [RD_LAT];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hCAFE0000 + 32'(i >> 4);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= rm_rd_en;
      pd[0] <= mem[rm_rd_addr[7:0]];
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      if (rm_wr_en)
        for (int b = 0; b < 4; b++)
          if (rm_wr_strb[b]) mem[rm_wr_addr[7:0]][8*b +: 8] <= rm_wr_data[8*b +: 8];
    end
  assign rm_rd_val  = pv[RD_LAT-1] | inj;
  assign rm_rd_data = inj ? 32'hDEADBEEF : pd[RD_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference model: grants from round-robin rules, reads queued with their due cycle and data
  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
  } rsp_t;
  rsp_t        q[$];
  logic [31:0] sh [256];
  int          cyc = 0, rl = 1, wl = 1;
  logic        pr_go, pw_go, err_m, rc, wc, go_r, go_w, e0, e1;
  logic [15:0] pr_addr, pw_addr, ra, wa;
  logic [31:0] pw_data, wd;
  logic [3:0]  pw_strb, ws;
  initial begin
    for (int i = 0; i < 256; i++) sh[i] = 32'hCAFE0000 + 32'(i >> 4);
    pr_go = 0; pw_go = 0; err_m = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_gnts", {28'd0, req0_rd_gnt, req1_rd_gnt, req0_wr_gnt, req1_wr_gnt}, 0);
        chk("rst_rm_en", {30'd0, rm_rd_en, rm_wr_en}, 0);
        chk("rst_vals", {30'd0, req0_rd_val, req1_rd_val}, 0);
        chk("rst_rd_data0", req0_rd_data, 0);
        chk("rst_rd_data1", req1_rd_data, 0);
        chk("rst_rm_wr_data", rm_wr_data, 0);
        chk("rst_err", err_orphan_rd, 0);
        q.delete();
        rl = 1; wl = 1; pr_go = 0; pw_go = 0; err_m = 0;
      end else begin
        rc   = (req0_rd_en && req1_rd_en) ? (rl == 0) : req1_rd_en;
        wc   = (req0_wr_en && req1_wr_en) ? (wl == 0) : req1_wr_en;
        ra   = rc ? req1_rd_addr : req0_rd_addr;
        wa   = wc ? req1_wr_addr : req0_wr_addr;
        go_w = req0_wr_en || req1_wr_en;
        go_r = (req0_rd_en || req1_rd_en) && !(go_w && wa == ra);
        chk("rd_gnt0", req0_rd_gnt, go_r && !rc);
        chk("rd_gnt1", req1_rd_gnt, go_r && rc);
        chk("wr_gnt0", req0_wr_gnt, go_w && !wc);
        chk("wr_gnt1", req1_wr_gnt, go_w && wc);
        chk("rm_rd_en", rm_rd_en, pr_go);
        if (pr_go) chk("rm_rd_addr", rm_rd_addr, pr_addr);
        chk("rm_wr_en", rm_wr_en, pw_go);
        if (pw_go) begin
          chk("rm_wr_addr", rm_wr_addr, pw_addr);
          chk("rm_wr_data", rm_wr_data, pw_data);
          chk("rm_wr_strb", rm_wr_strb, pw_strb);
        end
        e0 = q.size() > 0 && q[0].due == cyc && q[0].id == 0;
        e1 = q.size() > 0 && q[0].due == cyc && q[0].id == 1;
        chk("rd_val0", req0_rd_val, e0);
        chk("rd_val1", req1_rd_val, e1);
        if (e0) chk("rd_data0", req0_rd_data, q[0].data);
        if (e1) chk("rd_data1", req1_rd_data, q[0].data);
        if (e0 || e1) void'(q.pop_front());
        chk("err_orphan", err_orphan_rd, err_m);
        if (rm_rd_val && !(q.size() > 0 && q[0].due == cyc + 1)) err_m = 1;
        if (go_r) begin
          q.push_back('{cyc + RD_LAT + 2, rc, sh[ra[7:0]]});
          rl = int'(rc);
        end
        if (go_w) begin
          wd = wc ? req1_wr_data : req0_wr_data;
          ws = wc ? req1_wr_strb : req0_wr_strb;
          for (int b = 0; b < 4; b++) if (ws[b]) sh[wa[7:0]][8*b +: 8] = wd[8*b +: 8];
          wl = int'(wc);
        end
        pr_go = go_r; pr_addr = ra;
        pw_go = go_w; pw_addr = wa;
        pw_data = wc ? req1_wr_data : req0_wr_data;
        pw_strb = wc ? req1_wr_strb : req0_wr_strb;
      end
      cyc++;
    end
  end

  task automatic nxt(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    nxt(2);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; inj = 0;
    req0_rd_en = 0; req1_rd_en = 0; req0_wr_en = 0; req1_wr_en = 0;
    req0_rd_addr = 0; req1_rd_addr = 0; req0_wr_addr = 0; req1_wr_addr = 0;
    req0_wr_data = 0; req1_wr_data = 0; req0_wr_strb = 0; req1_wr_strb = 0;
    nxt(3);
    rst_n = 1;
    nxt(2);
    // single read from requester 0
    req0_rd_en = 1; req0_rd_addr = 16'h10;
    @(negedge clk);
    chk("s1_gnt0", req0_rd_gnt, 1);
    chk("s1_gnt1", req1_rd_gnt, 0);
    nxt(); req0_rd_en = 0;
    @(negedge clk);
    chk("s1_rm_en", rm_rd_en, 1);
    chk("s1_rm_addr", rm_rd_addr, 16'h10);
    nxt(3);
    @(negedge clk);
    chk("s1_val0", req0_rd_val, 1);
    chk("s1_data0", req0_rd_data, 32'hCAFE0001);
    chk("s1_val1", req1_rd_val, 0);
    nxt();
    @(negedge clk);
    chk("s1_val0_pulse", req0_rd_val, 0);
    // both requesters read for four cycles from a fresh pointer
    nxt(2);
    do_reset();
    req0_rd_en = 1; req0_rd_addr = 16'h30;
    req1_rd_en = 1; req1_rd_addr = 16'h40;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s2_gnt", {30'd0, req1_rd_gnt, req0_rd_gnt}, (k % 2) ? 32'd2 : 32'd1);
      nxt();
    end
    req0_rd_en = 0; req1_rd_en = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s2_rsp_val", {30'd0, req1_rd_val, req0_rd_val}, (k % 2) ? 32'd2 : 32'd1);
      chk("s2_rsp_data", (k % 2) ? req1_rd_data : req0_rd_data, (k % 2) ? 32'hCAFE0004 : 32'hCAFE0003);
      nxt();
    end
    nxt(2);
    // write and read of the same address in the same cycle
    req0_wr_en = 1; req0_wr_addr = 16'h20; req0_wr_data = 32'h55; req0_wr_strb = 4'hF;
    req1_rd_en = 1; req1_rd_addr = 16'h20;
    @(negedge clk);
    chk("s3_wr_gnt0", req0_wr_gnt, 1);
    chk("s3_rd_gnt1_held", req1_rd_gnt, 0);
    nxt(); req0_wr_en = 0;
    @(negedge clk);
    chk("s3_rd_gnt1", req1_rd_gnt, 1);
    chk("s3_rm_wr_data", rm_wr_data, 32'h55);
    nxt(); req1_rd_en = 0;
    nxt(3);
    @(negedge clk);
    chk("s3_val1", req1_rd_val, 1);
    chk("s3_data1", req1_rd_data, 32'h55);
    nxt(2);
    // contending writes, one with partial strobes, then read both back
    req1_wr_en = 1; req1_wr_addr = 16'h24; req1_wr_data = 32'hAABBCCDD; req1_wr_strb = 4'b0101;
    req0_wr_en = 1; req0_wr_addr = 16'h60; req0_wr_data = 32'h11111111; req0_wr_strb = 4'hF;
    @(negedge clk);
    chk("s3_wr_rr1", req1_wr_gnt, 1);
    chk("s3_wr_rr0_wait", req0_wr_gnt, 0);
    nxt(); req1_wr_en = 0;
    @(negedge clk);
    chk("s3_wr_rr0", req0_wr_gnt, 1);
    nxt(); req0_wr_en = 0;
    req0_rd_en = 1; req0_rd_addr = 16'h24;
    req1_rd_en = 1; req1_rd_addr = 16'h60;
    @(negedge clk);
    chk("s3_rd_rr0", req0_rd_gnt, 1);
    nxt(); req0_rd_en = 0;
    @(negedge clk);
    chk("s3_rd_rr1", req1_rd_gnt, 1);
    nxt(); req1_rd_en = 0;
    nxt(2);
    @(negedge clk);
    chk("s3_strb_data", req0_rd_data, 32'hCABB00DD);
    nxt();
    @(negedge clk);
    chk("s3_full_data", req1_rd_data, 32'h11111111);
    nxt(3);
    // orphan response with nothing in flight
    inj = 1;
    nxt(); inj = 0;
    @(negedge clk);
    chk("s4_err_set", err_orphan_rd, 1);
    nxt(5);
    @(negedge clk);
    chk("s4_err_sticky", err_orphan_rd, 1);
    chk("s4_no_val", {30'd0, req0_rd_val, req1_rd_val}, 0);
    // reset with two reads in flight
    nxt();
    do_reset();
    req0_rd_en = 1; req0_rd_addr = 16'h10;
    req1_rd_en = 1; req1_rd_addr = 16'h30;
    nxt(); req0_rd_en = 0;
    nxt(); req1_rd_en = 0;
    rst_n = 0;
    @(negedge clk);
    chk("s5_rst_rm_en", rm_rd_en, 0);
    chk("s5_rst_err", err_orphan_rd, 0);
    nxt(2);
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("s5_no_stale_val", {30'd0, req0_rd_val, req1_rd_val}, 0);
      nxt();
    end
    req1_rd_en = 1; req1_rd_addr = 16'h50;
    @(negedge clk);
    chk("s5_gnt1", req1_rd_gnt, 1);
    nxt(); req1_rd_en = 0;
    nxt(3);
    @(negedge clk);
    chk("s5_val1", req1_rd_val, 1);
    chk("s5_data1", req1_rd_data, 32'hCAFE0005);
    nxt(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
